// File: rtl/booth_pp_gen_24.sv
// Radix-4 Booth partial-product generator for the 24x24 mantissa multiplier; 1-cycle latency.
// Rows are held in a 2-entry elastic buffer; in_ready depends only on the stored count, never on out_ready.
module booth_pp_gen_24 #(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      in_a,
    input  logic [23:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [47:0]      pp1,
    output logic [47:0]      pp2,
    output logic [47:0]      pp3,
    output logic [47:0]      pp4,
    output logic [47:0]      pp5,
    output logic [47:0]      pp6,
    output logic [47:0]      pp7,
    output logic [47:0]      pp8,
    output logic [47:0]      pp9,
    output logic [47:0]      pp10,
    output logic [47:0]      pp11,
    output logic [47:0]      pp12,
    output logic [47:0]      pp13,
    output logic [9:0]       cin,
    output logic [TAG_W-1:0] out_tag
);

    function automatic logic booth_neg(input logic [2:0] g);
        return g[2] & ~(g[1] & g[0]);
    endfunction

    // One's-complemented magnitude for negative digits; the +1 goes into the next row.
    function automatic logic [25:0] booth_sel(input logic [2:0] g, input logic [23:0] a);
        logic        one;
        logic        two;
        logic [25:0] m;
        one = g[1] ^ g[0];
        two = (g == 3'b011) || (g == 3'b100);
        m   = '0;
        if (two)
            m = {1'b0, a, 1'b0};
        else if (one)
            m = {2'b00, a};
        return booth_neg(g) ? ~m : m;
    endfunction

    logic [26:0]       w_y;
    logic [25:0]       w_sel [13];
    logic [12:0][47:0] w_row;
    logic              w_push;
    logic              w_pop;
    logic [12:0][47:0] w_head;

    always_comb begin
        w_y   = {2'b00, in_b, 1'b0};
        w_row = '0;
        for (int i = 0; i < 13; i++) begin
            w_sel[i] = booth_sel(w_y[2*i +: 3], in_a);
            w_row[i] = {{22{w_sel[i][25]}}, w_sel[i]} << (2 * i);
        end
        for (int i = 0; i < 12; i++)
            w_row[i+1][2*i] = booth_neg(w_y[2*i +: 3]);
    end

    logic [12:0][47:0] r_mem_pp  [2];
    logic [TAG_W-1:0]  r_mem_tag [2];
    logic              r_wr;
    logic              r_rd;
    logic [1:0]        r_cnt;

    assign in_ready  = ~rst & (r_cnt != 2'd2);
    assign out_valid = (r_cnt != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push)
                r_wr <= ~r_wr;
            if (w_pop)
                r_rd <= ~r_rd;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pp[r_wr]  <= w_row;
            r_mem_tag[r_wr] <= in_tag;
        end
    end

    // Empty buffer drives zeros so stale or uninitialised entries never leak out.
    assign w_head  = out_valid ? r_mem_pp[r_rd] : '0;
    assign out_tag = out_valid ? r_mem_tag[r_rd] : '0;
    assign cin     = 10'b0;

    assign pp1  = w_head[0];
    assign pp2  = w_head[1];
    assign pp3  = w_head[2];
    assign pp4  = w_head[3];
    assign pp5  = w_head[4];
    assign pp6  = w_head[5];
    assign pp7  = w_head[6];
    assign pp8  = w_head[7];
    assign pp9  = w_head[8];
    assign pp10 = w_head[9];
    assign pp11 = w_head[10];
    assign pp12 = w_head[11];
    assign pp13 = w_head[12];

endmodule
